// File: rtl/alu_pkg.sv
`default_nettype none
//==========================================================================
// alu_pkg : opcodes, FSM states, op classes and flag bundle for alu_seq_ctrl
// Rev 1.0
//==========================================================================
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_NEG = 4'b0110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1000;
    localparam logic [3:0] OP_SAR = 4'b1001;
    localparam logic [3:0] OP_INC = 4'b1010;
    localparam logic [3:0] OP_DEC = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam logic [3:0] OP_CMP = 4'b1101;
    localparam logic [3:0] OP_LDI = 4'b1110;
    localparam logic [3:0] OP_ILL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_CMP = 2'd1,
        CLS_LDI = 2'd2,
        CLS_ILL = 2'd3
    } op_class_t;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic op_class_t op_class(input logic [3:0] op);
        op_class_t cls;
        case (op)
            OP_CMP:  cls = CLS_CMP;
            OP_LDI:  cls = CLS_LDI;
            OP_ILL:  cls = CLS_ILL;
            default: cls = CLS_ALU;
        endcase
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
//==========================================================================
// alu_seq_ctrl_if : command and response handshakes of alu_seq_ctrl
// Rev 1.0
//==========================================================================
interface alu_seq_ctrl_if #(
    parameter int REG_AW = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [REG_AW-1:0] cmd_rd;
    logic [REG_AW-1:0] cmd_rs1;
    logic [REG_AW-1:0] cmd_rs2;
    logic              cmd_use_imm;
    logic [7:0]        cmd_imm;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_result;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
//==========================================================================
// alu_regfile : REG_COUNT x 8 registers, one write port, three async reads
// Rev 1.0
//==========================================================================
module alu_regfile #(
    parameter int REG_COUNT = 4,
    parameter int REG_AW    = 2
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              we,
    input  wire [REG_AW-1:0] waddr,
    input  wire [7:0]        wdata,
    input  wire [REG_AW-1:0] raddr_a,
    output logic [7:0]       rdata_a,
    input  wire [REG_AW-1:0] raddr_b,
    output logic [7:0]       rdata_b,
    input  wire [REG_AW-1:0] raddr_dbg,
    output logic [7:0]       rdata_dbg
);

    logic [7:0] r_regs [REG_COUNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (we) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign rdata_a   = r_regs[raddr_a];
    assign rdata_b   = r_regs[raddr_b];
    assign rdata_dbg = r_regs[raddr_dbg];

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
//==========================================================================
// alu_seq_ctrl : sequences commands through the external 8-bit alu
// Rev 1.0
//==========================================================================
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int REG_COUNT = 4,
    parameter int REG_AW    = 2
) (
    input  wire               clk,
    input  wire               rst_n,
    alu_seq_ctrl_if.slave     bus,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [3:0]        alu_op,
    input  wire  [7:0]        alu_result,
    input  wire               alu_zero,
    input  wire               alu_carry,
    input  wire               alu_overflow,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v,
    input  wire  [REG_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_we;
    logic [7:0]        w_wdata;
    logic [7:0]        w_rs1_data;
    logic [7:0]        w_rs2_data;

    logic [REG_AW-1:0] r_rd;
    op_class_t         r_cls;
    logic [7:0]        r_imm;
    flags_t            r_flags;
    logic              r_rsp_valid;
    logic [7:0]        r_rsp_result;
    logic              r_rsp_err;

    alu_regfile #(
        .REG_COUNT (REG_COUNT),
        .REG_AW    (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (w_we),
        .waddr     (r_rd),
        .wdata     (w_wdata),
        .raddr_a   (bus.cmd_rs1),
        .rdata_a   (w_rs1_data),
        .raddr_b   (bus.cmd_rs2),
        .rdata_b   (w_rs2_data),
        .raddr_dbg (dbg_addr),
        .rdata_dbg (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The register write happens on the edge that leaves EXEC, so the
    // result is visible one cycle before the response can be consumed.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_we        = 1'b0;
        w_wdata     = alu_result;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
                w_we        = (r_cls == CLS_ALU) || (r_cls == CLS_LDI);
                w_wdata     = (r_cls == CLS_LDI) ? r_imm : alu_result;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a        <= 8'h00;
            alu_b        <= 8'h00;
            alu_op       <= 4'h0;
            r_rd         <= '0;
            r_cls        <= CLS_ALU;
            r_imm        <= 8'h00;
            r_flags      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 8'h00;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                alu_a  <= w_rs1_data;
                alu_b  <= bus.cmd_use_imm ? bus.cmd_imm : w_rs2_data;
                alu_op <= bus.cmd_op;
                r_rd   <= bus.cmd_rd;
                r_cls  <= op_class(bus.cmd_op);
                r_imm  <= bus.cmd_imm;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_valid <= 1'b1;
                case (r_cls)
                    CLS_ALU, CLS_CMP: begin
                        r_flags      <= '{z: alu_zero, c: alu_carry, v: alu_overflow};
                        r_rsp_result <= alu_result;
                        r_rsp_err    <= 1'b0;
                    end
                    CLS_LDI: begin
                        r_rsp_result <= r_imm;
                        r_rsp_err    <= 1'b0;
                    end
                    default: begin
                        r_rsp_result <= 8'h00;
                        r_rsp_err    <= 1'b1;
                    end
                endcase
            end
            if ((r_state == ST_RESP) && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready  = (r_state == ST_IDLE);
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_err    = r_rsp_err;
    assign flag_z         = r_flags.z;
    assign flag_c         = r_flags.c;
    assign flag_v         = r_flags.v;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
//==========================================================================
// tb_alu_seq_ctrl : directed vector table plus stall and reset-abort sequences
// Rev 1.0
//==========================================================================
module tb_alu_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [3:0] alu_op;
    logic       alu_zero, alu_carry, alu_overflow;
    logic       flag_z, flag_c, flag_v;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_seq_ctrl_if #(.REG_AW(2)) bus ();

    alu_seq_ctrl #(
        .REG_COUNT (4),
        .REG_AW    (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .flag_v       (flag_v),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference alu: SUB/CMP/DEC carry is the borrow; op 1111/1110 return 0xA5
    // so a stray write-back of the alu result is visible.
    always_comb begin
        logic [8:0] t;
        t            = 9'h000;
        alu_result   = 8'h00;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op)
            4'h0: begin
                t = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = t[7:0];
                alu_carry    = t[8];
                alu_overflow = (alu_a[7] == alu_b[7]) && (t[7] != alu_a[7]);
            end
            4'h1, 4'hD: begin
                t = {1'b0, alu_a} - {1'b0, alu_b};
                alu_result   = t[7:0];
                alu_carry    = t[8];
                alu_overflow = (alu_a[7] != alu_b[7]) && (t[7] != alu_a[7]);
            end
            4'h2: alu_result = alu_a & alu_b;
            4'h3: alu_result = alu_a | alu_b;
            4'h4: alu_result = alu_a ^ alu_b;
            4'h5: alu_result = ~alu_a;
            4'h6: alu_result = 8'h00 - alu_a;
            4'h7: alu_result = alu_a << alu_b[2:0];
            4'h8: alu_result = alu_a >> alu_b[2:0];
            4'h9: alu_result = 8'($signed(alu_a) >>> alu_b[2:0]);
            4'hA: begin
                t = {1'b0, alu_a} + 9'h001;
                alu_result   = t[7:0];
                alu_carry    = t[8];
                alu_overflow = (alu_a == 8'h7F);
            end
            4'hB: begin
                t = {1'b0, alu_a} - 9'h001;
                alu_result   = t[7:0];
                alu_carry    = t[8];
                alu_overflow = (alu_a == 8'h80);
            end
            4'hC: alu_result = alu_a * alu_b;
            default: alu_result = 8'hA5;
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    typedef struct {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic       use_imm;
        logic [7:0] imm;
        logic [7:0] res;
        logic       err;
        logic [2:0] zcv;
        logic [1:0] chk;
        logic [7:0] reg_val;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        bus.cmd_op      = v.op;
        bus.cmd_rd      = v.rd;
        bus.cmd_rs1     = v.rs1;
        bus.cmd_rs2     = v.rs2;
        bus.cmd_use_imm = v.use_imm;
        bus.cmd_imm     = v.imm;
        bus.cmd_valid   = 1'b1;
        dbg_addr        = v.chk;
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk({tag, "_exec_no_rsp"}, 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_result"}, 32'(bus.rsp_result), 32'(v.res));
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'(v.err));
        chk({tag, "_flags_zcv"}, 32'({flag_z, flag_c, flag_v}), 32'(v.zcv));
        chk({tag, "_reg"}, 32'(dbg_data), 32'(v.reg_val));
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        // op rd rs1 rs2 imm? imm | result err zcv chk-reg value
        vecs[0]  = '{4'hE, 2'd0, 2'd0, 2'd0, 1'b1, 8'h7F, 8'h7F, 1'b0, 3'b000, 2'd0, 8'h7F};
        vecs[1]  = '{4'hE, 2'd1, 2'd0, 2'd0, 1'b1, 8'h01, 8'h01, 1'b0, 3'b000, 2'd1, 8'h01};
        vecs[2]  = '{4'h0, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h80, 1'b0, 3'b001, 2'd2, 8'h80};
        vecs[3]  = '{4'hE, 2'd0, 2'd0, 2'd0, 1'b1, 8'h05, 8'h05, 1'b0, 3'b001, 2'd0, 8'h05};
        vecs[4]  = '{4'hD, 2'd3, 2'd0, 2'd0, 1'b1, 8'h05, 8'h00, 1'b0, 3'b100, 2'd3, 8'h00};
        vecs[5]  = '{4'h1, 2'd3, 2'd0, 2'd0, 1'b1, 8'h06, 8'hFF, 1'b0, 3'b010, 2'd3, 8'hFF};
        vecs[6]  = '{4'h0, 2'd2, 2'd3, 2'd1, 1'b0, 8'h00, 8'h00, 1'b0, 3'b110, 2'd2, 8'h00};
        vecs[7]  = '{4'hF, 2'd3, 2'd3, 2'd1, 1'b0, 8'h00, 8'h00, 1'b1, 3'b110, 2'd3, 8'hFF};
        vecs[8]  = '{4'hE, 2'd1, 2'd0, 2'd0, 1'b1, 8'h80, 8'h80, 1'b0, 3'b110, 2'd1, 8'h80};
        vecs[9]  = '{4'h9, 2'd1, 2'd1, 2'd0, 1'b1, 8'h03, 8'hF0, 1'b0, 3'b000, 2'd1, 8'hF0};
        vecs[10] = '{4'hA, 2'd1, 2'd1, 2'd0, 1'b0, 8'h00, 8'hF1, 1'b0, 3'b000, 2'd1, 8'hF1};
        vecs[11] = '{4'hB, 2'd0, 2'd2, 2'd0, 1'b0, 8'h00, 8'hFF, 1'b0, 3'b010, 2'd0, 8'hFF};

        rst_n           = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 4'h0;
        bus.cmd_rd      = 2'd0;
        bus.cmd_rs1     = 2'd0;
        bus.cmd_rs2     = 2'd0;
        bus.cmd_use_imm = 1'b0;
        bus.cmd_imm     = 8'h00;
        bus.rsp_ready   = 1'b0;
        dbg_addr        = 2'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_flags", 32'({flag_z, flag_c, flag_v}), 32'd0);
        chk("rst_alu_regs", 32'({alu_a, alu_b, alu_op}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            dbg_addr = 2'(r);
            #1;
            chk($sformatf("rst_reg%0d", r), 32'(dbg_data), 32'd0);
        end
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Response stalled 5 cycles while a second command waits on cmd_valid.
        @(negedge clk);
        dbg_addr        = 2'd0;
        bus.cmd_op      = 4'hE;
        bus.cmd_rd      = 2'd0;
        bus.cmd_use_imm = 1'b1;
        bus.cmd_imm     = 8'h3C;
        bus.cmd_valid   = 1'b1;
        @(posedge clk); #1;
        bus.cmd_imm = 8'h11;
        chk("stall_exec_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("stall%0d_rsp_result", k), 32'(bus.rsp_result), 32'h3C);
            chk($sformatf("stall%0d_cmd_ready", k), 32'(bus.cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        chk("stall_flags_held", 32'({flag_z, flag_c, flag_v}), 32'b010);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("stall_after_hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("stall_after_hs_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("stall_second_not_taken", 32'(dbg_data), 32'h3C);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk("second_accepted", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("second_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("second_rsp_result", 32'(bus.rsp_result), 32'h11);
        chk("second_reg0", 32'(dbg_data), 32'h11);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;

        // Reset asserted while ADD r2 = r0 + r0 is in EXEC.
        @(negedge clk);
        dbg_addr        = 2'd2;
        bus.cmd_op      = 4'h0;
        bus.cmd_rd      = 2'd2;
        bus.cmd_rs1     = 2'd0;
        bus.cmd_rs2     = 2'd0;
        bus.cmd_use_imm = 1'b0;
        bus.cmd_valid   = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_flags", 32'({flag_z, flag_c, flag_v}), 32'd0);
        chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("abort_reg2", 32'(dbg_data), 32'd0);
        @(posedge clk); #1;
        chk("abort_hold_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_release_reg2", 32'(dbg_data), 32'd0);
        dbg_addr = 2'd0;
        #1;
        chk("abort_release_reg0", 32'(dbg_data), 32'd0);

        apply('{4'hE, 2'd2, 2'd0, 2'd0, 1'b1, 8'h5A, 8'h5A, 1'b0, 3'b000, 2'd2, 8'h5A}, "post_ldi");
        apply('{4'h0, 2'd3, 2'd2, 2'd2, 1'b0, 8'h00, 8'hB4, 1'b0, 3'b001, 2'd3, 8'hB4}, "post_add");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
